bp_table_ctrl: RTL and testbench
================================

// Module: bp_table_ctrl
// PURPOSE
//  Owns a table of 2-bit saturating branch counters (2**IDX_W entries). Shares the table's
//  single access slot between the fetch lookup port and the commit update port.
//  Lookups have priority. Updates are buffered in a small FIFO and drained in idle slots.
//  Sits between fetch/commit and replaces per-branch predictor instances.
// PARAMETERS
//  IDX_W     4      table index width; table holds 2**IDX_W counters
//  UQ_DEPTH  2      update FIFO depth (>=1)
//  CNT_INIT  2'd3   value loaded into every counter by INIT (strongly taken)
// PORTS
//  clk         in   1      single clock; all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  flush       in   1      drops queued updates and re-initialises the table
//  lk_valid    in   1      lookup request
//  lk_idx      in   IDX_W  lookup index
//  lk_ready    out  1      lookup accepted when lk_valid && lk_ready
//  pred_valid  out  1      prediction valid, one cycle after accept
//  pred_taken  out  1      predicted direction (counter MSB)
//  up_valid    in   1      resolved-branch update request
//  up_idx      in   IDX_W  update index
//  up_taken    in   1      resolved direction
//  up_ready    out  1      update enqueued when up_valid && up_ready
//  busy        out  1      high while in INIT
// BEHAVIOUR
//  - Reset values: state=INIT, init_ptr=0, FIFO empty, lk_ready=0, up_ready=0,
//    pred_valid=0, pred_taken=0, busy=1.
//  - FSM INIT: writes CNT_INIT to entry init_ptr each cycle, then increments init_ptr.
//    After entry 2**IDX_W-1 it moves to RUN, so INIT lasts exactly 2**IDX_W cycles.
//    lk_ready=0 and up_ready=0 throughout INIT.
//  - FSM RUN: stays in RUN until rst or flush.
//  - flush (any state): clears the FIFO, sets init_ptr=0, enters INIT next cycle.
//    In that cycle no lookup or update is accepted, and pred_valid is 0 next cycle.
//    rst overrides flush.
//  - lk_ready = RUN && !fifo_full.
//  - up_ready = RUN && !fifo_full (derived from registered count only).
//  - Slot arbitration in RUN, one table access per cycle:
//    lookup accepted -> lookup uses the slot;
//    otherwise, FIFO non-empty -> head update is applied and popped.
//    When the FIFO is full, lk_ready=0, so the head update drains that cycle.
//  - Lookup latency 1: accept in cycle N gives pred_valid=1 in N+1, with pred_taken =
//    counter[lk_idx][1] as of cycle N. There is no bypass from queued updates.
//    pred_valid=0 in any cycle following a non-accept.
//  - Update arithmetic: taken -> cnt = (cnt==3) ? 3 : cnt+1;
//    not-taken -> cnt = (cnt==0) ? 0 : cnt-1. No wrap-around.
//  - An update enqueued in cycle N reaches the table in cycle N+1 at the earliest.
//  - Enqueue and pop may occur in the same cycle when the FIFO is not full; count is unchanged.
//  - Updates are applied in FIFO order. Repeated updates to the same index accumulate.
// STRUCTURE
//  - Package bp_pkg: typedef logic [1:0] bp_cnt_t; constants CNT_SNT=0, CNT_WNT=1, CNT_WT=2,
//    CNT_ST=3; enum bp_state_e {BP_INIT, BP_RUN}; function bp_sat_update(bp_cnt_t, logic taken).
//  - Sub-module bp_update_fifo:
//    ports clk, rst, clr, push, push_data{idx,taken}, pop, head, empty, full.
//    Synchronous, UQ_DEPTH entries, pointer wrap modulo UQ_DEPTH.
//  - Top level holds the counter array, the FSM and the slot arbiter.
// TESTING
//  1. Init: rst 1 cycle -> busy=1 and lk_ready=0 for 16 cycles, then ready.
//     Lookup idx 5 -> pred_valid=1, pred_taken=1 next cycle.
//  2. Saturation: lk_valid=0, 4 not-taken updates idx 2 -> counter 3,2,1,0,0.
//     Lookup idx 2 -> pred_taken=0. Then 2 taken updates -> counter 2; lookup -> pred_taken=1.
//  3. Priority: lk_valid held 1, 2 updates pushed -> FIFO full and lk_ready=0, up_ready=0.
//     That cycle drains one update; lk_ready=1 the next cycle.
//  4. Stale read: enqueue not-taken idx 7 in the same cycle as lookup idx 7 (counter 3)
//     -> pred_taken=1. A repeat lookup after the drain -> pred_taken=1 (counter 2).
//  5. Flush: FIFO holds 2 not-taken updates for idx 1, pulse flush -> FIFO empty, INIT 16 cycles.
//     Lookup idx 1 -> pred_taken=1 (counter 3, updates dropped).
//  6. rst at init_ptr=9 restarts the sweep -> exactly 16 more INIT cycles before lk_ready=1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor counter table.
// Counter encoding, controller states and saturating counter arithmetic.
package bp_pkg;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t CNT_SNT = 2'd0;
    localparam bp_cnt_t CNT_WNT = 2'd1;
    localparam bp_cnt_t CNT_WT  = 2'd2;
    localparam bp_cnt_t CNT_ST  = 2'd3;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_e;

    // Two-bit saturating step; never wraps past either end.
    function automatic bp_cnt_t bp_sat_update(
        input bp_cnt_t cnt,
        input logic    taken
    );
        bp_cnt_t nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) begin
                nxt = cnt + 2'd1;
            end
        end else begin
            if (cnt != CNT_SNT) begin
                nxt = cnt - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO buffering resolved-branch updates
// until the counter table has a free access slot.
module bp_update_fifo #(
    parameter int DW    = 5,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (w_push && !rst && !clr) begin
            r_mem[r_wptr] <= push_data;
        end
    end

endmodule

// File: rtl/bp_table_ctrl.sv
// Shared 2-bit counter table: fetch lookups win the single access slot,
// commit updates queue in a FIFO and drain whenever the slot is idle.
module bp_table_ctrl
    import bp_pkg::*;
#(
    parameter int      IDX_W    = 4,
    parameter int      UQ_DEPTH = 2,
    parameter bp_cnt_t CNT_INIT = 2'd3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_idx,
    input  logic             up_taken,
    output logic             up_ready,
    output logic             busy
);

    localparam int N  = 2 ** IDX_W;
    localparam int DW = IDX_W + 1;

    bp_state_e        r_state;
    logic [IDX_W-1:0] r_init_ptr;
    bp_cnt_t          r_cnt [N];
    logic             r_pred_valid;
    logic             r_pred_taken;

    logic             w_run;
    logic             w_full;
    logic             w_empty;
    logic [DW-1:0]    w_head;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;
    logic             w_lk_acc;
    logic             w_up_acc;
    logic             w_pop;

    assign w_run        = (r_state == BP_RUN);
    assign lk_ready     = w_run && !w_full;
    assign up_ready     = w_run && !w_full;
    assign busy         = !w_run;
    assign pred_valid   = r_pred_valid;
    assign pred_taken   = r_pred_taken;
    assign w_head_idx   = w_head[DW-1:1];
    assign w_head_taken = w_head[0];

    // A flush cycle accepts nothing on either port.
    assign w_lk_acc = lk_valid && lk_ready && !flush;
    assign w_up_acc = up_valid && up_ready && !flush;
    assign w_pop    = w_run && !flush && !w_lk_acc && !w_empty;

    bp_update_fifo #(
        .DW    (DW),
        .DEPTH (UQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (w_up_acc),
        .push_data ({up_idx, up_taken}),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BP_INIT;
            r_init_ptr   <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else if (flush) begin
            r_state      <= BP_INIT;
            r_init_ptr   <= '0;
            r_pred_valid <= 1'b0;
        end else begin
            r_pred_valid <= w_lk_acc;
            if (w_lk_acc) begin
                r_pred_taken <= r_cnt[lk_idx][1];
            end
            unique case (r_state)
                BP_INIT: begin
                    r_init_ptr <= r_init_ptr + IDX_W'(1);
                    if (r_init_ptr == '1) begin
                        r_state <= BP_RUN;
                    end
                end
                BP_RUN: begin
                    r_state <= BP_RUN;
                end
                default: begin
                    r_state <= BP_INIT;
                end
            endcase
        end
    end

    // Table contents are defined by the INIT sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (!w_run) begin
                r_cnt[r_init_ptr] <= CNT_INIT;
            end else if (w_pop) begin
                r_cnt[w_head_idx] <= bp_sat_update(r_cnt[w_head_idx], w_head_taken);
            end
        end
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl: expected predictions are queued
// at lookup accept and compared when pred_valid appears.
module tb_bp_table_ctrl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       lk_valid;
    logic [3:0] lk_idx;
    logic       lk_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic       up_valid;
    logic [3:0] up_idx;
    logic       up_taken;
    logic       up_ready;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_q [$];

    bp_table_ctrl #(
        .IDX_W    (4),
        .UQ_DEPTH (2),
        .CNT_INIT (2'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .lk_valid   (lk_valid),
        .lk_idx     (lk_idx),
        .lk_ready   (lk_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .up_valid   (up_valid),
        .up_idx     (up_idx),
        .up_taken   (up_taken),
        .up_ready   (up_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && pred_valid) begin
            if (exp_q.size() == 0) begin
                chk("pred_spurious", 32'(pred_valid), 32'd0);
            end else begin
                chk("pred_taken", 32'(pred_taken), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_init(input string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (busy && n < 64) begin
            if (lk_ready || up_ready) bad++;
            n++;
            @(negedge clk);
        end
        chk({tag, "_cycles"}, 32'(n), 32'd16);
        chk({tag, "_rdy_in_init"}, 32'(bad), 32'd0);
        chk({tag, "_lk_ready"}, 32'(lk_ready), 32'd1);
    endtask

    task automatic lookup(input logic [3:0] idx, input logic exp);
        int n;
        lk_valid = 1'b1;
        lk_idx   = idx;
        n = 0;
        while (!lk_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("lk_timeout", 32'(lk_ready), 32'd1);
        end else begin
            exp_q.push_back(exp);
        end
        @(negedge clk);
        lk_valid = 1'b0;
    endtask

    task automatic update(input logic [3:0] idx, input logic tkn);
        int n;
        up_valid = 1'b1;
        up_idx   = idx;
        up_taken = tkn;
        n = 0;
        while (!up_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("up_timeout", 32'(up_ready), 32'd1);
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        lk_valid = 1'b0;
        lk_idx   = '0;
        up_valid = 1'b0;
        up_idx   = '0;
        up_taken = 1'b0;
        idle(3);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_lk_ready", 32'(lk_ready), 32'd0);
        chk("rst_up_ready", 32'(up_ready), 32'd0);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);

        // Init sweep then a first lookup.
        rst = 1'b0;
        count_init("init");
        lookup(4'd5, 1'b1);
        idle(2);

        // Saturation on idx 2: 3 -> 2 -> 1 -> 0 -> 0, then up to 2.
        update(4'd2, 1'b0);
        idle(2);
        lookup(4'd2, 1'b1);
        update(4'd2, 1'b0);
        idle(2);
        lookup(4'd2, 1'b0);
        update(4'd2, 1'b0);
        update(4'd2, 1'b0);
        idle(2);
        lookup(4'd2, 1'b0);
        update(4'd2, 1'b1);
        idle(2);
        lookup(4'd2, 1'b0);
        update(4'd2, 1'b1);
        idle(2);
        lookup(4'd2, 1'b1);
        idle(2);

        // Priority: lookups every cycle fill the FIFO, full forces a drain.
        lk_valid = 1'b1;
        lk_idx   = 4'd0;
        up_valid = 1'b1;
        up_idx   = 4'd3;
        up_taken = 1'b1;
        chk("prio_lk_rdy0", 32'(lk_ready), 32'd1);
        chk("prio_up_rdy0", 32'(up_ready), 32'd1);
        exp_q.push_back(1'b1);
        @(negedge clk);
        up_idx = 4'd4;
        chk("prio_lk_rdy1", 32'(lk_ready), 32'd1);
        chk("prio_up_rdy1", 32'(up_ready), 32'd1);
        exp_q.push_back(1'b1);
        @(negedge clk);
        up_valid = 1'b0;
        chk("prio_full_lk_rdy", 32'(lk_ready), 32'd0);
        chk("prio_full_up_rdy", 32'(up_ready), 32'd0);
        @(negedge clk);
        chk("prio_after_drain_lk_rdy", 32'(lk_ready), 32'd1);
        exp_q.push_back(1'b1);
        @(negedge clk);
        lk_valid = 1'b0;
        idle(3);

        // Stale read: no bypass from a same-cycle enqueue.
        lk_valid = 1'b1;
        lk_idx   = 4'd7;
        up_valid = 1'b1;
        up_idx   = 4'd7;
        up_taken = 1'b0;
        chk("stale_lk_rdy", 32'(lk_ready), 32'd1);
        chk("stale_up_rdy", 32'(up_ready), 32'd1);
        exp_q.push_back(1'b1);
        @(negedge clk);
        lk_valid = 1'b0;
        up_valid = 1'b0;
        idle(2);
        lookup(4'd7, 1'b1);
        update(4'd7, 1'b0);
        idle(2);
        lookup(4'd7, 1'b0);
        idle(2);

        // Flush with two queued not-taken updates for idx 1.
        lk_valid = 1'b1;
        lk_idx   = 4'd0;
        up_valid = 1'b1;
        up_idx   = 4'd1;
        up_taken = 1'b0;
        exp_q.push_back(1'b1);
        @(negedge clk);
        exp_q.push_back(1'b1);
        @(negedge clk);
        lk_valid = 1'b0;
        up_valid = 1'b0;
        flush    = 1'b1;
        chk("flush_fifo_full", 32'(up_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_pred_valid", 32'(pred_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        count_init("flush");
        lookup(4'd1, 1'b1);
        lookup(4'd7, 1'b1);
        idle(2);

        // Reset in the middle of a sweep restarts it from entry 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(9);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_pred_valid", 32'(pred_valid), 32'd0);
        count_init("mid_rst");
        lookup(4'd2, 1'b1);
        idle(3);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
